// File: rtl/flash_op_scheduler.sv
// flash_op_scheduler
//   Round-robin arbiter that shares the single NAND flash operation engine
//   among four requesters (0 data write, 1 info-page write, 2 log write,
//   3 erase). It grants one requester, waits for R/B, issues a one-cycle
//   start, then holds the grant until the engine finishes or the timeout
//   counter expires, and returns a per-requester done/fail pulse.
//
// Ports
//   clk          system clock, rising edge
//   rst          synchronous active-low reset
//   req[3:0]     level requests, held until req_done/req_fail of that index
//   flash_ready  NAND R/B (1 = device idle)
//   op_done      one-cycle completion pulse from the engine
//   op_fail      qualifies op_done, 1 = status fail
//   grant[3:0]   one-hot registered grant
//   op_sel[1:0]  index of granted requester
//   op_start     one-cycle start pulse to the engine
//   req_done     one-hot one-cycle success pulse
//   req_fail     one-hot one-cycle fail/timeout pulse
//   timeout      one-cycle timeout abort pulse
//   busy         scheduler not idle (registered view of state)
module flash_op_scheduler #(
    parameter int unsigned TIMEOUT_CYC = 1000000,
    parameter int unsigned CNT_W       = 24
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic       flash_ready,
    input  logic       op_done,
    input  logic       op_fail,
    output logic [3:0] grant,
    output logic [1:0] op_sel,
    output logic       op_start,
    output logic [3:0] req_done,
    output logic [3:0] req_fail,
    output logic       timeout,
    output logic       busy
);

    typedef enum logic [2:0] {
        IDLE,
        ARB,
        WAIT_RDY,
        ISSUE,
        WAIT_DONE,
        RELEASE
    } state_t;

    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYC - 1);

    state_t           state, state_n;
    logic [1:0]       ptr, ptr_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [3:0]       grant_n;
    logic [1:0]       op_sel_n;
    logic             op_start_n;
    logic [3:0]       req_done_n;
    logic [3:0]       req_fail_n;
    logic             timeout_n;
    logic             busy_n;

    logic             win_found;
    logic [1:0]       win_idx;
    logic [3:0]       sel_onehot;
    logic             cnt_hit;

    // Search from ptr+1 upward (mod 4) so the last winner has lowest priority.
    always_comb begin
        win_found = 1'b0;
        win_idx   = ptr;
        for (int unsigned i = 1; i <= 4; i++) begin
            if (!win_found && req[ptr + 2'(i)]) begin
                win_found = 1'b1;
                win_idx   = ptr + 2'(i);
            end
        end
    end

    assign sel_onehot = 4'b0001 << op_sel;
    // >= rather than == so a start issued right at the limit still aborts
    // on the first WAIT_DONE cycle instead of waiting forever.
    assign cnt_hit    = (cnt >= TMO_LAST);

    always_comb begin
        state_n    = state;
        ptr_n      = ptr;
        cnt_n      = cnt;
        grant_n    = grant;
        op_sel_n   = op_sel;
        op_start_n = 1'b0;
        req_done_n = '0;
        req_fail_n = '0;
        timeout_n  = 1'b0;
        busy_n     = (state != IDLE);

        case (state)
            IDLE: begin
                grant_n = '0;
                if (|req) begin
                    state_n = ARB;
                end
            end

            ARB: begin
                if (win_found) begin
                    grant_n  = 4'b0001 << win_idx;
                    op_sel_n = win_idx;
                    ptr_n    = win_idx;
                    cnt_n    = '0;
                    state_n  = WAIT_RDY;
                end else begin
                    state_n = IDLE;
                end
            end

            WAIT_RDY: begin
                cnt_n = cnt + 1'b1;
                if (!req[op_sel]) begin
                    state_n = RELEASE;
                end else if (flash_ready) begin
                    op_start_n = 1'b1;
                    state_n    = ISSUE;
                end else if (cnt_hit) begin
                    timeout_n  = 1'b1;
                    req_fail_n = sel_onehot;
                    state_n    = RELEASE;
                end
            end

            ISSUE: begin
                cnt_n   = cnt + 1'b1;
                state_n = WAIT_DONE;
            end

            WAIT_DONE: begin
                cnt_n = cnt + 1'b1;
                // Completion wins over a timeout landing on the same cycle.
                if (op_done) begin
                    if (op_fail) begin
                        req_fail_n = sel_onehot;
                    end else begin
                        req_done_n = sel_onehot;
                    end
                    state_n = RELEASE;
                end else if (cnt_hit) begin
                    timeout_n  = 1'b1;
                    req_fail_n = sel_onehot;
                    state_n    = RELEASE;
                end
            end

            RELEASE: begin
                grant_n = '0;
                state_n = IDLE;
            end

            default: begin
                grant_n = '0;
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            ptr      <= 2'd3;
            cnt      <= '0;
            grant    <= '0;
            op_sel   <= '0;
            op_start <= 1'b0;
            req_done <= '0;
            req_fail <= '0;
            timeout  <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state    <= state_n;
            ptr      <= ptr_n;
            cnt      <= cnt_n;
            grant    <= grant_n;
            op_sel   <= op_sel_n;
            op_start <= op_start_n;
            req_done <= req_done_n;
            req_fail <= req_fail_n;
            timeout  <= timeout_n;
            busy     <= busy_n;
        end
    end

endmodule

// File: tb/tb_flash_op_scheduler.sv
// Testbench for flash_op_scheduler. Stimulus pushes expected output events
// (with the cycle they must appear in) into a queue; a negedge monitor pops
// and compares each event the DUT presents.
module tb_flash_op_scheduler;

    localparam int TMO = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic       flash_ready;
    logic       op_done;
    logic       op_fail;
    logic [3:0] grant;
    logic [1:0] op_sel;
    logic       op_start;
    logic [3:0] req_done;
    logic [3:0] req_fail;
    logic       timeout;
    logic       busy;

    flash_op_scheduler #(
        .TIMEOUT_CYC(TMO),
        .CNT_W      (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .flash_ready(flash_ready),
        .op_done    (op_done),
        .op_fail    (op_fail),
        .grant      (grant),
        .op_sel     (op_sel),
        .op_start   (op_start),
        .req_done   (req_done),
        .req_fail   (req_fail),
        .timeout    (timeout),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        int         cyc;
        logic [3:0] grant;
        logic [1:0] sel;
        logic       start;
        logic [3:0] done;
        logic [3:0] fail;
        logic       to;
    } ev_t;

    ev_t sb[$];
    int  errors = 0;
    int  checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input int c, input int w, input logic st,
                        input logic [3:0] dn, input logic [3:0] fl, input logic to);
        ev_t e;
        e.cyc   = c;
        e.grant = 4'b0001 << w;
        e.sel   = 2'(w);
        e.start = st;
        e.done  = dn;
        e.fail  = fl;
        e.to    = to;
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: any pulse or a fresh grant is an event to be matched.
    logic [3:0] prev_grant = '0;
    always @(negedge clk) begin
        ev_t a;
        ev_t e;
        if (op_start || (|req_done) || (|req_fail) || timeout ||
            (grant != 4'b0 && grant != prev_grant)) begin
            a.cyc   = cyc;
            a.grant = grant;
            a.sel   = op_sel;
            a.start = op_start;
            a.done  = req_done;
            a.fail  = req_fail;
            a.to    = timeout;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: got cyc=%0d grant=%b sel=%0d start=%b done=%b fail=%b to=%b, expected no event",
                         a.cyc, a.grant, a.sel, a.start, a.done, a.fail, a.to);
            end else begin
                e = sb.pop_front();
                if (a !== e) begin
                    errors++;
                    $display("FAIL sb_event: got cyc=%0d grant=%b sel=%0d start=%b done=%b fail=%b to=%b, expected cyc=%0d grant=%b sel=%0d start=%b done=%b fail=%b to=%b",
                             a.cyc, a.grant, a.sel, a.start, a.done, a.fail, a.to,
                             e.cyc, e.grant, e.sel, e.start, e.done, e.fail, e.to);
                end
            end
        end
        prev_grant = grant;
    end

    // One full operation starting with the DUT idle. d = cycles from op_start
    // to the result pulse (op_done driven one cycle earlier); d = 0 means the
    // engine never answers and the timeout must fire. The requester drops its
    // bit during RELEASE and req becomes r_after one cycle later.
    task automatic do_op(input logic [3:0] r, input int w, input int d,
                         input logic f, input logic [3:0] r_after);
        int k, s, m;
        k = cyc;
        req = r;
        flash_ready = 1'b1;
        s = k + 3;
        m = (d == 0) ? s + TMO - 1 : s + d;
        push(k + 2, w, 1'b0, 4'b0, 4'b0, 1'b0);
        push(s, w, 1'b1, 4'b0, 4'b0, 1'b0);
        if (d == 0)
            push(m, w, 1'b0, 4'b0, 4'b0001 << w, 1'b1);
        else if (f)
            push(m, w, 1'b0, 4'b0, 4'b0001 << w, 1'b0);
        else
            push(m, w, 1'b0, 4'b0001 << w, 4'b0, 1'b0);
        tick();
        chk("arb_busy", 32'(busy), 32'd0);
        tick();
        chk("grant_busy", 32'(busy), 32'd1);
        if (d != 0) begin
            while (cyc < s + d - 1) tick();
            op_done = 1'b1;
            op_fail = f;
            tick();
            op_done = 1'b0;
            op_fail = 1'b0;
        end
        while (cyc < m) tick();
        req = r & ~(4'b0001 << w);
        tick();
        chk("release_grant", 32'(grant), 32'd0);
        chk("release_busy", 32'(busy), 32'd1);
        req = r_after;
    endtask

    initial begin
        int k;
        rst = 1'b0;
        req = '0;
        flash_ready = 1'b0;
        op_done = 1'b0;
        op_fail = 1'b0;
        repeat (3) tick();
        chk("reset_outputs", 32'({grant, op_sel, op_start, req_done, req_fail, timeout, busy}), 32'd0);
        rst = 1'b1;
        tick();

        // Round robin from reset: 0,1,2,3,0 then with req[1] dropped: 2,3,0,2
        do_op(4'b1111, 0, 4, 1'b0, 4'b1111);
        do_op(4'b1111, 1, 4, 1'b0, 4'b1111);
        do_op(4'b1111, 2, 4, 1'b0, 4'b1111);
        do_op(4'b1111, 3, 4, 1'b0, 4'b1111);
        do_op(4'b1111, 0, 4, 1'b0, 4'b1101);
        do_op(4'b1101, 2, 4, 1'b0, 4'b1101);
        do_op(4'b1101, 3, 4, 1'b0, 4'b1101);
        do_op(4'b1101, 0, 4, 1'b0, 4'b1101);
        do_op(4'b1101, 2, 4, 1'b0, 4'b0000);

        // Single log-write request, then busy must be low
        do_op(4'b0100, 2, 6, 1'b0, 4'b0000);
        tick();
        chk("idle_busy", 32'(busy), 32'd0);

        // Engine reports fail
        do_op(4'b0010, 1, 3, 1'b1, 4'b0000);

        // op_done on the exact timeout cycle: done wins, no timeout
        do_op(4'b1000, 3, TMO - 1, 1'b0, 4'b0000);

        // Engine never answers: timeout from WAIT_DONE
        do_op(4'b0001, 0, 0, 1'b0, 4'b0000);

        // Flash never ready: timeout from WAIT_RDY, no op_start
        k = cyc;
        req = 4'b0010;
        flash_ready = 1'b0;
        push(k + 2, 1, 1'b0, 4'b0, 4'b0, 1'b0);
        push(k + 2 + TMO, 1, 1'b0, 4'b0, 4'b0010, 1'b1);
        while (cyc < k + 2 + TMO) tick();
        req = '0;
        tick();
        chk("rdy_tmo_grant", 32'(grant), 32'd0);

        // Withdrawal in WAIT_RDY, then a stray op_done while idle
        k = cyc;
        req = 4'b0001;
        push(k + 2, 0, 1'b0, 4'b0, 4'b0, 1'b0);
        while (cyc < k + 3) tick();
        req = '0;
        tick();
        chk("withdraw_release_grant", 32'(grant), 32'd1);
        tick();
        chk("withdraw_grant", 32'(grant), 32'd0);
        op_done = 1'b1;
        tick();
        op_done = 1'b0;
        chk("stray_done_outputs", 32'({grant, op_start, req_done, req_fail, timeout, busy}), 32'd0);

        // Reset during WAIT_DONE, then ptr must be back at 3 (index 0 first)
        k = cyc;
        req = 4'b0001;
        flash_ready = 1'b1;
        push(k + 2, 0, 1'b0, 4'b0, 4'b0, 1'b0);
        push(k + 3, 0, 1'b1, 4'b0, 4'b0, 1'b0);
        while (cyc < k + 5) tick();
        rst = 1'b0;
        tick();
        chk("midop_reset_outputs", 32'({grant, op_sel, op_start, req_done, req_fail, timeout, busy}), 32'd0);
        rst = 1'b1;
        req = '0;
        tick();
        do_op(4'b1001, 0, 3, 1'b0, 4'b1000);
        do_op(4'b1000, 3, 3, 1'b0, 4'b0000);

        repeat (4) tick();
        chk("sb_drain", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
